// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_rx #(
  parameter int clk_freq     = 50000000,
  parameter int baudrate     = 9600,
  parameter int tick_per_bit = clk_freq / baudrate
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CW = (tick_per_bit > 1) ? $clog2(tick_per_bit) : 1;
  localparam logic [CW-1:0] LAST = CW'(tick_per_bit - 1);
  localparam logic [CW-1:0] HALF = CW'(tick_per_bit / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          perr;
  logic          rx;
  logic          fall;
  logic          tick;

  assign rx   = sync2;
  assign fall = prev & ~sync2;
  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= data_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
  assign perr       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      data_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr       <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          // busy from the previous frame covers its pulse cycle, then drops
          busy <= fall;
          cnt  <= '0;
          idx  <= '0;
`ifdef UART_RX_PARITY_EN
          perr <= 1'b0;
`endif
          if (fall) state <= START;
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (rx) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            cnt <= '0;
            sh  <= {rx, sh[7:1]};
            idx <= idx + 1'b1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            cnt   <= '0;
            perr  <= rx ^ (^sh);
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            cnt   <= '0;
            state <= IDLE;
            if (perr) begin
`ifdef UART_RX_PARITY_EN
              parity_err <= 1'b1;
`endif
            end else if (rx) begin
              done     <= 1'b1;
              data_out <= sh;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit.
// Build with UART_RX_PARITY_EN to cover the parity frames.
module tb_uart_rx;

  localparam int T = 10;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = T / 2 + 10 * T + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int LAT = T / 2 + 9 * T + 1;
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         c0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_in;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic       frame_err;
  logic       parity_err;

  exp_t       q[$];
  logic [7:0] last_good;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  uart_rx #(
    .clk_freq(1000000),
    .baudrate(100000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .data_out(data_out),
    .busy(busy),
    .done(done),
    .frame_err(frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic v);
    data_in = v;
    repeat (T) @(negedge clk);
  endtask

  // kind one-hot: {parity_err, frame_err, done}
  task automatic send(input logic [7:0] b, input logic stop_bit,
                      input logic par_bit);
    exp_t e;
    e.c0 = cyc;
    if (PAR && (par_bit != ^b)) e.kind = 3'b100;
    else if (!stop_bit) e.kind = 3'b010;
    else e.kind = 3'b001;
    if (e.kind == 3'b001) last_good = b;
    e.data = last_good;
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (done || frame_err || parity_err)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {29'd0, parity_err, frame_err, done}, 0);
      end else begin
        e = q.pop_front();
        check("pulse_kind", {29'd0, parity_err, frame_err, done},
              {29'd0, e.kind});
        check("data_out", {24'd0, data_out}, {24'd0, e.data});
        check("busy_at_pulse", {31'd0, busy}, 1);
        // two extra cycles for the input synchronizer
        check("latency", cyc - e.c0, LAT + 2);
      end
    end
  end

  initial begin
    last_good = 8'h00;
    rst_n   = 1'b0;
    data_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", {24'd0, data_out}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_errs", {30'd0, frame_err, parity_err}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send(8'h55, 1'b1, ^8'h55);
    repeat (20) @(negedge clk);
    check("idle_busy_55", {31'd0, busy}, 0);
    check("hold_55", {24'd0, data_out}, 8'h55);

    // bad stop bit, then line held low as a break
    send(8'hA3, 1'b0, ^8'hA3);
    data_in = 1'b0;
    repeat (30) @(negedge clk);
    check("break_busy", {31'd0, busy}, 0);
    data_in = 1'b1;
    repeat (20) @(negedge clk);
    check("hold_after_ferr", {24'd0, data_out}, 8'h55);

    data_in = 1'b0;
    repeat (3) @(negedge clk);
    data_in = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 0);
    repeat (10) @(negedge clk);

    send(8'h00, 1'b1, ^8'h00);
    send(8'hFF, 1'b1, ^8'hFF);
    repeat (20) @(negedge clk);
    check("b2b_last", {24'd0, data_out}, 8'hFF);

    // abort a frame in the middle of bit 4
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    data_in = 1'b1;
    repeat (T / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_data_out", {24'd0, data_out}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_pulses", {29'd0, parity_err, frame_err, done}, 0);
    last_good = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 0);
    send(8'h3C, 1'b1, ^8'h3C);
    repeat (20) @(negedge clk);
    check("hold_3c", {24'd0, data_out}, 8'h3C);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("hold_after_perr", {24'd0, data_out}, 8'h3C);
    send(8'h07, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("par_ok_07", {24'd0, data_out}, 8'h07);
`endif

    repeat (20) @(negedge clk);
    check("pending", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
